os_mesh: RTL

OS_MESH -- requirements
Module: os_mesh

---
 rtl/os_mesh.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/os_mesh.sv
// rtl/os_mesh.sv - output-stationary systolic mesh computing C = A*B, one C row per drain beat
// Define OS_MESH_SATURATE_EN for clamped accumulation with a sticky per-job ovf flag.
module os_mesh #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int INW  = 8,
  parameter int ACCW = 32,
  parameter int KMAX = 256
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(KMAX+1)-1:0]   k_len,
  input  logic [ROWS*INW-1:0]         in_a,
  input  logic [COLS*INW-1:0]         in_b,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [COLS*ACCW-1:0]        out_c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        ovf
);
  localparam int KW = $clog2(KMAX + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(ROWS + COLS);
`ifdef OS_MESH_SATURATE_EN
  localparam int SW = ACCW + 1;
`else
  localparam int SW = ACCW;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t          state;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   row;
  logic            accept;
  logic            clear_acc;

  assign accept    = in_valid && in_ready;
  assign clear_acc = (state == S_IDLE) && start;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          k_reg     <= k_len;
          beat_cnt  <= '0;
          flush_cnt <= '0;
          row       <= '0;
          busy      <= 1'b1;
          if (k_len == '0) begin
            state <= S_FLUSH;
          end else begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
          end
        end
        S_LOAD: if (accept) begin
          beat_cnt <= beat_cnt + KW'(1);
          if (beat_cnt == k_reg - KW'(1)) begin
            state    <= S_FLUSH;
            in_ready <= 1'b0;
          end
        end
        S_FLUSH: begin
          // Long enough for the last beat to reach PE(ROWS-1,COLS-1)
          flush_cnt <= flush_cnt + FW'(1);
          if (flush_cnt == FW'(ROWS + COLS - 2)) begin
            state     <= S_DRAIN;
            out_valid <= 1'b1;
            out_last  <= (ROWS == 1);
          end
        end
        S_DRAIN: if (out_valid && out_ready) begin
          if (row == RW'(ROWS - 1)) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            row       <= '0;
          end else begin
            row      <= row + RW'(1);
            out_last <= (row == RW'(ROWS - 2));
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic signed [INW-1:0]  a_edge [ROWS];
  logic                   a_edge_v [ROWS];
  logic signed [INW-1:0]  b_edge [COLS];
  logic                   b_edge_v [COLS];

  for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
    if (i == 0) begin : g_direct
      assign a_edge[i]   = in_a[INW-1:0];
      assign a_edge_v[i] = accept;
    end else begin : g_delay
      logic [INW-1:0] d [i];
      logic           dv [i];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int s = 0; s < i; s++) begin
            d[s]  <= '0;
            dv[s] <= 1'b0;
          end
        end else begin
          d[0]  <= in_a[i*INW +: INW];
          dv[0] <= accept;
          for (int s = 1; s < i; s++) begin
            d[s]  <= d[s-1];
            dv[s] <= dv[s-1];
          end
        end
      end
      assign a_edge[i]   = d[i-1];
      assign a_edge_v[i] = dv[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_skew_b
    if (j == 0) begin : g_direct
      assign b_edge[j]   = in_b[INW-1:0];
      assign b_edge_v[j] = accept;
    end else begin : g_delay
      logic [INW-1:0] d [j];
      logic           dv [j];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int s = 0; s < j; s++) begin
            d[s]  <= '0;
            dv[s] <= 1'b0;
          end
        end else begin
          d[0]  <= in_b[j*INW +: INW];
          dv[0] <= accept;
          for (int s = 1; s < j; s++) begin
            d[s]  <= d[s-1];
            dv[s] <= dv[s-1];
          end
        end
      end
      assign b_edge[j]   = d[j-1];
      assign b_edge_v[j] = dv[j-1];
    end
  end

  logic signed [INW-1:0]  a_q [ROWS][COLS];
  logic                   a_v [ROWS][COLS];
  logic signed [INW-1:0]  b_q [ROWS][COLS];
  logic                   b_v [ROWS][COLS];
  logic signed [ACCW-1:0] acc [ROWS][COLS];
`ifdef OS_MESH_SATURATE_EN
  logic [ROWS*COLS-1:0]   clamp_vec;
`endif

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_pe
      logic signed [INW-1:0]   a_in;
      logic signed [INW-1:0]   b_in;
      logic                    a_in_v;
      logic                    b_in_v;
      logic signed [2*INW-1:0] prod;
      logic signed [SW-1:0]    sum;
      logic signed [ACCW-1:0]  nxt;
      logic                    hit;

      if (j == 0) begin : g_west
        assign a_in   = a_edge[i];
        assign a_in_v = a_edge_v[i];
      end else begin : g_east
        assign a_in   = a_q[i][j-1];
        assign a_in_v = a_v[i][j-1];
      end
      if (i == 0) begin : g_north
        assign b_in   = b_edge[j];
        assign b_in_v = b_edge_v[j];
      end else begin : g_south
        assign b_in   = b_q[i-1][j];
        assign b_in_v = b_v[i-1][j];
      end

      assign hit  = a_v[i][j] && b_v[i][j];
      assign prod = (2*INW)'(a_q[i][j]) * (2*INW)'(b_q[i][j]);
      assign sum  = SW'(acc[i][j]) + SW'(prod);
`ifdef OS_MESH_SATURATE_EN
      // One extra sum bit: disagreement with the sign bit means the result left ACCW range
      assign clamp_vec[i*COLS+j] = hit && (sum[ACCW] != sum[ACCW-1]);
      assign nxt = !clamp_vec[i*COLS+j] ? sum[ACCW-1:0] :
                   sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
`else
      assign nxt = sum;
`endif

      always_ff @(posedge clock) begin
        if (reset) begin
          a_q[i][j] <= '0;
          a_v[i][j] <= 1'b0;
          b_q[i][j] <= '0;
          b_v[i][j] <= 1'b0;
          acc[i][j] <= '0;
        end else begin
          a_q[i][j] <= a_in;
          a_v[i][j] <= a_in_v;
          b_q[i][j] <= b_in;
          b_v[i][j] <= b_in_v;
          if (clear_acc)
            acc[i][j] <= '0;
          else if (hit)
            acc[i][j] <= nxt;
        end
      end
    end
  end

`ifdef OS_MESH_SATURATE_EN
  always_ff @(posedge clock) begin
    if (reset || clear_acc)
      ovf <= 1'b0;
    else if (|clamp_vec)
      ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    out_c = '0;
    for (int j = 0; j < COLS; j++)
      if (out_valid)
        out_c[j*ACCW +: ACCW] = acc[row][j];
  end

endmodule
